// File: rtl/dino_pkg.sv
// Shared game-flow constants used by the game controller, scene renderer and collision block.
package dino_pkg;

  localparam logic [1:0] GS_IDLE = 2'b00;
  localparam logic [1:0] GS_RUN  = 2'b01;
  localparam logic [1:0] GS_OVER = 2'b10;

  localparam int unsigned SCREEN_W = 640;
  localparam int unsigned SCROLL_W = 10;
  localparam int unsigned SPEED_W  = 4;
  localparam int unsigned SCORE_W  = 16;

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchroniser for an asynchronous level followed by a registered rising-edge pulse.
module sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic pulse
);

  logic [2:0] sync_q;

  // sync_q[1:0] is the metastability chain; sync_q[2] holds the previous synchronised level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 3'b000;
      pulse  <= 1'b0;
    end else begin
      sync_q <= {sync_q[1:0], async_in};
      pulse  <= sync_q[1] & ~sync_q[2];
    end
  end

endmodule

// File: rtl/scene_game_ctrl.sv
// Game-flow controller: IDLE/RUN/OVER sequencing, scroll offset, score, speed ramp and restart hold-off.
module scene_game_ctrl
  import dino_pkg::*;
#(
  parameter int unsigned SPEED_INIT = 2,
  parameter int unsigned SPEED_MAX  = 8,
  parameter int unsigned SPEED_STEP = 100,
  parameter int unsigned SCORE_DIV  = 10,
  parameter int unsigned OVER_HOLD  = 50
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clk_100Hz,
  input  logic                btn_jump,
  input  logic                collision,
  output logic [1:0]          game_state,
  output logic [SCROLL_W-1:0] scroll_x,
  output logic [SPEED_W-1:0]  speed,
  output logic [SCORE_W-1:0]  score,
  output logic                tick
);

  localparam int unsigned DIV_W  = (SCORE_DIV > 1) ? $clog2(SCORE_DIV) : 1;
  localparam int unsigned HOLD_W = $clog2(OVER_HOLD + 1);
  localparam int unsigned STEP_W = (SPEED_STEP > 1) ? $clog2(SPEED_STEP) : 1;
  localparam int unsigned SUM_W  = SCROLL_W + 1;

  logic                press;
  logic [1:0]          state_q,  state_d;
  logic [SCROLL_W-1:0] scroll_q, scroll_d;
  logic [SPEED_W-1:0]  speed_q,  speed_d;
  logic [SCORE_W-1:0]  score_q,  score_d;
  logic [DIV_W-1:0]    div_q,    div_d;
  logic [HOLD_W-1:0]   hold_q,   hold_d;
  logic [STEP_W-1:0]   step_q,   step_d;
  logic [SUM_W-1:0]    scroll_sum;
  logic [SCROLL_W-1:0] scroll_wrap;

  sync_edge u_sync_tick (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (clk_100Hz),
    .pulse    (tick)
  );

  sync_edge u_sync_btn (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (btn_jump),
    .pulse    (press)
  );

  // speed never exceeds SCREEN_W, so a single conditional subtract implements the modulus
  assign scroll_sum  = {1'b0, scroll_q} + SUM_W'(speed_q);
  assign scroll_wrap = (scroll_sum >= SUM_W'(SCREEN_W)) ? SCROLL_W'(scroll_sum - SUM_W'(SCREEN_W))
                                                        : SCROLL_W'(scroll_sum);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= GS_IDLE;
      scroll_q <= '0;
      speed_q  <= SPEED_W'(SPEED_INIT);
      score_q  <= '0;
      div_q    <= '0;
      hold_q   <= '0;
      step_q   <= '0;
    end else begin
      state_q  <= state_d;
      scroll_q <= scroll_d;
      speed_q  <= speed_d;
      score_q  <= score_d;
      div_q    <= div_d;
      hold_q   <= hold_d;
      step_q   <= step_d;
    end
  end

  // step_q tracks score mod SPEED_STEP so the speed bump needs no divider
  always_comb begin
    state_d  = state_q;
    scroll_d = scroll_q;
    speed_d  = speed_q;
    score_d  = score_q;
    div_d    = div_q;
    hold_d   = hold_q;
    step_d   = step_q;
    case (state_q)
      GS_IDLE: begin
        if (press) begin
          state_d  = GS_RUN;
          scroll_d = '0;
          speed_d  = SPEED_W'(SPEED_INIT);
          score_d  = '0;
          div_d    = '0;
          step_d   = '0;
        end
      end
      GS_RUN: begin
        if (collision) begin
          state_d = GS_OVER;
          hold_d  = '0;
        end else if (tick) begin
          scroll_d = scroll_wrap;
          if (div_q == DIV_W'(SCORE_DIV - 1)) begin
            div_d = '0;
            if (score_q != '1) begin
              score_d = score_q + SCORE_W'(1);
              if (step_q == STEP_W'(SPEED_STEP - 1)) begin
                step_d = '0;
                if (speed_q < SPEED_W'(SPEED_MAX)) speed_d = speed_q + SPEED_W'(1);
              end else begin
                step_d = step_q + STEP_W'(1);
              end
            end
          end else begin
            div_d = div_q + DIV_W'(1);
          end
        end
      end
      GS_OVER: begin
        if (tick && (hold_q < HOLD_W'(OVER_HOLD))) hold_d = hold_q + HOLD_W'(1);
        if (press && (hold_q == HOLD_W'(OVER_HOLD))) state_d = GS_IDLE;
      end
      default: state_d = GS_IDLE;
    endcase
  end

  assign game_state = state_q;
  assign scroll_x   = scroll_q;
  assign speed      = speed_q;
  assign score      = score_q;

endmodule

// File: tb/tb_scene_game_ctrl.sv
// Randomised bench for scene_game_ctrl against a rule-level model of the game flow.
module tb_scene_game_ctrl;
  import dino_pkg::*;

  localparam int T_SPEED_INIT = 2;
  localparam int T_SPEED_MAX  = 8;
  localparam int T_SPEED_STEP = 100;
  localparam int T_SCORE_DIV  = 10;
  localparam int T_OVER_HOLD  = 50;
  localparam int T_SCORE_SAT  = 65535;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clk_100Hz = 1'b0;
  logic        btn_jump = 1'b0;
  logic        collision = 1'b0;
  logic [1:0]  game_state;
  logic [9:0]  scroll_x;
  logic [3:0]  speed;
  logic [15:0] score;
  logic        tick;

  int n_cmp = 0;
  int n_bad = 0;
  int max_speed_seen = 0;
  bit btn_hold = 1'b0;
  bit rand_btn = 1'b0;

  scene_game_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clk_100Hz  (clk_100Hz),
    .btn_jump   (btn_jump),
    .collision  (collision),
    .game_state (game_state),
    .scroll_x   (scroll_x),
    .speed      (speed),
    .score      (score),
    .tick       (tick)
  );

  always #5 clk = ~clk;

  // Model: game rules over integers; raw async samples kept as a short history per clk edge
  typedef struct {
    int st;
    int scroll;
    int score;
    int ticks_in_score;
    int hold;
    int run_ticks;
    int over_ticks;
    bit tick;
    bit press;
    bit [3:0] ht;
    bit [3:0] hb;
  } model_t;

  model_t m;

  function automatic int speed_of(int sc);
    int s = T_SPEED_INIT + sc / T_SPEED_STEP;
    return (s > T_SPEED_MAX) ? T_SPEED_MAX : s;
  endfunction

  function automatic model_t reset_model();
    model_t r;
    r.st = 0; r.scroll = 0; r.score = 0; r.ticks_in_score = 0; r.hold = 0;
    r.run_ticks = 0; r.over_ticks = 0; r.tick = 1'b0; r.press = 1'b0;
    r.ht = 4'b0; r.hb = 4'b0;
    return r;
  endfunction

  function automatic model_t step(model_t c, bit s, bit b, bit col);
    model_t n = c;
    if (c.st == 0) begin
      if (c.press) begin
        n.st = 1; n.scroll = 0; n.score = 0; n.ticks_in_score = 0; n.run_ticks = 0;
      end
    end else if (c.st == 1) begin
      if (col) begin
        n.st = 2; n.hold = 0; n.over_ticks = 0;
      end else if (c.tick) begin
        n.scroll = (c.scroll + speed_of(c.score)) % int'(SCREEN_W);
        n.run_ticks = c.run_ticks + 1;
        n.ticks_in_score = c.ticks_in_score + 1;
        if (n.ticks_in_score == T_SCORE_DIV) begin
          n.ticks_in_score = 0;
          if (c.score < T_SCORE_SAT) n.score = c.score + 1;
        end
      end
    end else begin
      if (c.press && c.hold == T_OVER_HOLD) n.st = 0;
      if (c.tick) begin
        n.hold = (c.hold < T_OVER_HOLD) ? c.hold + 1 : T_OVER_HOLD;
        n.over_ticks = c.over_ticks + 1;
      end
    end
    // a level first seen at edge j-2 and absent at edge j-3 shows up as a pulse after edge j
    n.ht = {c.ht[2:0], s};
    n.hb = {c.hb[2:0], b};
    n.tick  = n.ht[2] & ~n.ht[3];
    n.press = n.hb[2] & ~n.hb[3];
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= reset_model();
    else        m <= step(m, clk_100Hz, btn_jump, collision);
  end

  task automatic check(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cycle_compare();
    int es;
    es = speed_of(m.score);
    if (int'(speed) > max_speed_seen) max_speed_seen = int'(speed);
    n_cmp++;
    if (int'(game_state) != m.st || int'(scroll_x) != m.scroll || int'(speed) != es ||
        int'(score) != m.score || tick != m.tick) begin
      n_bad++;
      $display("FAIL cycle t=%0t: state %0d/%0d scroll %0d/%0d speed %0d/%0d score %0d/%0d tick %0d/%0d (got/expected)",
               $time, game_state, m.st, scroll_x, m.scroll, speed, es, score, m.score, tick, m.tick);
    end
  endtask

  task automatic step_neg();
    @(negedge clk);
    if (rst_n) cycle_compare();
  endtask

  task automatic timeout(string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: timed out waiting", name);
  endtask

  task automatic wait_run(int target);
    for (int i = 0; i < 40000; i++) begin
      if (m.run_ticks >= target && m.st == 1) return;
      step_neg();
    end
    timeout("wait_run");
  endtask

  task automatic wait_over(int target);
    for (int i = 0; i < 5000; i++) begin
      if (m.over_ticks >= target && m.st == 2) return;
      step_neg();
    end
    timeout("wait_over");
  endtask

  task automatic wait_tick_visible();
    for (int i = 0; i < 200; i++) begin
      if (m.tick) return;
      step_neg();
    end
    timeout("wait_tick");
  endtask

  task automatic press_btn();
    btn_hold = 1'b1;
    repeat (4) step_neg();
    btn_hold = 1'b0;
  endtask

  task automatic check_reset_values(string tag);
    check({tag, "_state"}, int'(game_state), 0);
    check({tag, "_scroll"}, int'(scroll_x), 0);
    check({tag, "_speed"}, int'(speed), T_SPEED_INIT);
    check({tag, "_score"}, int'(score), 0);
    check({tag, "_tick"}, int'(tick), 0);
  endtask

  // Slow strobe, asynchronous to clk: transitions never land on a rising clk edge
  initial begin
    int unsigned w;
    #2;
    forever begin
      w = ($urandom_range(0, 7) == 0) ? 10 : $urandom_range(12, 35);
      #($urandom_range(12, 35));
      while ($time % 10 == 5) #1;
      clk_100Hz = 1'b1;
      #(w);
      while ($time % 10 == 5) #1;
      clk_100Hz = 1'b0;
    end
  end

  // Button driver: either follows btn_hold or toggles randomly
  initial begin
    forever begin
      @(negedge clk);
      #3;
      if (rand_btn) begin
        if ($urandom_range(0, 29) == 0) btn_jump = ~btn_jump;
      end else begin
        btn_jump = btn_hold;
      end
    end
  end

  initial begin
    repeat (3) step_neg();
    check_reset_values("por");
    #3 rst_n = 1'b1;
    step_neg();

    // first run: basic scroll/score, then collision on a tick at scroll 100
    press_btn();
    check("start_state", int'(game_state), 1);
    wait_run(5);
    check("t5_scroll", int'(scroll_x), 10);
    check("t5_score", int'(score), 0);
    wait_run(10);
    check("t10_scroll", int'(scroll_x), 20);
    check("t10_score", int'(score), 1);
    wait_run(50);
    check("t50_scroll", int'(scroll_x), 100);
    wait_tick_visible();
    collision = 1'b1;
    step_neg();
    collision = 1'b0;
    check("col_state", int'(game_state), 2);
    check("col_scroll", int'(scroll_x), 100);
    check("col_score", int'(score), 5);

    // restart hold-off
    wait_over(10);
    press_btn();
    repeat (6) step_neg();
    check("early_press_state", int'(game_state), 2);
    wait_over(T_OVER_HOLD + 1);
    press_btn();
    repeat (4) step_neg();
    check("late_press_state", int'(game_state), 0);
    check("idle_score_held", int'(score), 5);

    // second run: asynchronous reset mid-game
    press_btn();
    wait_run(150);
    check("pre_rst_scroll", int'(scroll_x), 300);
    #3 rst_n = 1'b0;
    #1 check_reset_values("mid_rst");
    step_neg();
    step_neg();
    #3 rst_n = 1'b1;
    step_neg();
    check("post_rst_state", int'(game_state), 0);

    // third run: wrap, speed ramp, ceiling; presses during RUN are ignored
    press_btn();
    rand_btn = 1'b1;
    wait_run(319);
    check("wrap_pre_scroll", int'(scroll_x), 638);
    wait_run(320);
    check("wrap_scroll", int'(scroll_x), 0);
    wait_run(1000);
    check("t1000_score", int'(score), 100);
    check("t1000_speed", int'(speed), 3);
    wait_run(6500);
    check("t6500_score", int'(score), 650);
    check("t6500_speed", int'(speed), T_SPEED_MAX);
    check("speed_ceiling", (max_speed_seen > T_SPEED_MAX) ? 1 : 0, 0);

    // random collisions and button activity across all states
    for (int i = 0; i < 4000; i++) begin
      collision = ($urandom_range(0, 199) == 0);
      step_neg();
    end
    collision = 1'b0;
    step_neg();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
